// File: rtl/demux1x4_collector.sv
// demux1x4_collector: steers serial bits into 4 lanes and emits the assembled word on a valid/ready port
module demux1x4_collector #(
  parameter int N = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             din,
  input  logic [SEL_W-1:0] sel,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     dout,
  output logic [N-1:0]     filled,
  output logic             dup_err
);
  typedef enum logic {COLLECT, HOLD} state_t;
  state_t state, state_n;
  logic [N-1:0] dout_n, filled_n;
  logic accept, dup_n;
  assign in_ready = state == COLLECT;
  assign out_valid = state == HOLD;
  assign accept = in_valid & in_ready;
  always_comb begin
    state_n = state;
    dout_n = dout;
    filled_n = filled;
    dup_n = 1'b0;
    if (state == COLLECT) begin
      if (accept) begin
        dout_n[sel] = din;
        filled_n[sel] = 1'b1;
        dup_n = filled[sel];
      end
      state_n = (&filled_n || (flush && (|filled || accept))) ? HOLD : COLLECT;
    end else if (out_ready) begin
      state_n = COLLECT;
      dout_n = '0;
      filled_n = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= COLLECT;
      dout <= '0;
      filled <= '0;
      dup_err <= 1'b0;
    end else begin
      state <= state_n;
      dout <= dout_n;
      filled <= filled_n;
      dup_err <= dup_n;
    end
endmodule
